// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch button conditioning: two-flop synchronisers, per-input debounce,
// one-shot start/stop commands (stop has priority), a clean countdown-mode
// level, and hold-to-repeat on the minute/hour increment buttons.
module stopwatch_btn_ctrl #(
    parameter int unsigned DEB_CNT   = 3,
    parameter int unsigned REP_DELAY = 50,
    parameter int unsigned REP_RATE  = 20
) (
    input  logic clk_100Hz,
    input  logic rst,
    input  logic btn_start_raw,
    input  logic btn_stop_raw,
    input  logic btn_min_raw,
    input  logic btn_hour_raw,
    input  logic sw_mode_raw,
    output logic start,
    output logic stop,
    output logic min_inc,
    output logic hour_inc,
    output logic countdown_mode
);

    // Input bit positions: 0 start, 1 stop, 2 min, 3 hour, 4 mode switch
    localparam int unsigned N_IN      = 5;
    localparam logic [3:0] DEB_LIMIT  = 4'(DEB_CNT);
    localparam logic [7:0] DELAY_LOAD = 8'(REP_DELAY - 1);
    localparam logic [7:0] RATE_LOAD  = 8'(REP_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    logic [N_IN-1:0] raw_s;
    logic [N_IN-1:0] s1_r;
    logic [N_IN-1:0] s2_r;
    logic [N_IN-1:0] deb_s;
    logic [N_IN-1:0] deb_d_r;
    logic [N_IN-1:0] rise_s;
    logic [1:0]      inc_pulse_s;
    logic            start_r;
    logic            stop_r;
    logic            mode_r;

    assign raw_s = {sw_mode_raw, btn_hour_raw, btn_min_raw, btn_stop_raw, btn_start_raw};

    // Two-flop synchroniser for every raw input; nothing between the stages
    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            s1_r <= 5'd0;
            s2_r <= 5'd0;
        end else begin
            s1_r <= raw_s;
            s2_r <= s1_r;
        end
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
        logic [3:0] cnt_r;
        logic       lvl_r;

        // Accept a new level only after DEB_CNT consecutive disagreeing samples
        always_ff @(posedge clk_100Hz or posedge rst) begin
            if (rst) begin
                cnt_r <= 4'd0;
                lvl_r <= 1'b0;
            end else if (s2_r[gi] == lvl_r) begin
                cnt_r <= 4'd0;
            end else if ((cnt_r + 4'd1) == DEB_LIMIT) begin
                cnt_r <= 4'd0;
                lvl_r <= s2_r[gi];
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end

        assign deb_s[gi] = lvl_r;
    end

    // Delayed copy of the debounced levels for rising-edge detection
    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            deb_d_r <= 5'd0;
        end else begin
            deb_d_r <= deb_s;
        end
    end

    assign rise_s = deb_s & ~deb_d_r;

    // Registered command outputs; a simultaneous start is dropped in favour of stop
    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            start_r <= 1'b0;
            stop_r  <= 1'b0;
            mode_r  <= 1'b0;
        end else begin
            start_r <= rise_s[0] & ~rise_s[1];
            stop_r  <= rise_s[1];
            mode_r  <= deb_s[4];
        end
    end

    for (genvar gk = 0; gk < 2; gk++) begin : g_rep
        localparam int unsigned IDX = gk + 2;

        rep_state_t state_r;
        rep_state_t state_s;
        logic [7:0] cnt_r;
        logic [7:0] cnt_s;
        logic       pulse_s;
        logic       pulse_r;

        // Repeat FSM state, countdown and registered pulse
        always_ff @(posedge clk_100Hz or posedge rst) begin
            if (rst) begin
                state_r <= ST_IDLE;
                cnt_r   <= 8'd0;
                pulse_r <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                pulse_r <= pulse_s;
            end
        end

        // Next state: initial pulse on press, long first delay, then fixed cadence
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            pulse_s = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s[IDX]) begin
                        pulse_s = 1'b1;
                        cnt_s   = DELAY_LOAD;
                        state_s = ST_WAIT;
                    end else begin
                        cnt_s   = 8'd0;
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT, ST_REPEAT: begin
                    if (!deb_s[IDX]) begin
                        cnt_s   = 8'd0;
                        state_s = ST_IDLE;
                    end else if (cnt_r == 8'd0) begin
                        pulse_s = 1'b1;
                        cnt_s   = RATE_LOAD;
                        state_s = ST_REPEAT;
                    end else begin
                        cnt_s   = cnt_r - 8'd1;
                        state_s = state_r;
                    end
                end
                default: begin
                    cnt_s   = 8'd0;
                    state_s = ST_IDLE;
                end
            endcase
        end

        assign inc_pulse_s[gk] = pulse_r;
    end

    assign start          = start_r;
    assign stop           = stop_r;
    assign min_inc        = inc_pulse_s[0];
    assign hour_inc       = inc_pulse_s[1];
    assign countdown_mode = mode_r;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Testbench for stopwatch_btn_ctrl: directed scenarios plus random button
// activity, every cycle compared against a behavioural model.
module tb_stopwatch_btn_ctrl;

    localparam int DEB_CNT   = 3;
    localparam int REP_DELAY = 50;
    localparam int REP_RATE  = 20;

    logic clk_100Hz = 1'b0;
    logic rst = 1'b1;
    logic btn_start_raw = 1'b0;
    logic btn_stop_raw  = 1'b0;
    logic btn_min_raw   = 1'b0;
    logic btn_hour_raw  = 1'b0;
    logic sw_mode_raw   = 1'b0;
    logic start, stop, min_inc, hour_inc, countdown_mode;

    stopwatch_btn_ctrl #(
        .DEB_CNT(DEB_CNT), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
    ) dut (
        .clk_100Hz(clk_100Hz), .rst(rst),
        .btn_start_raw(btn_start_raw), .btn_stop_raw(btn_stop_raw),
        .btn_min_raw(btn_min_raw), .btn_hour_raw(btn_hour_raw),
        .sw_mode_raw(sw_mode_raw),
        .start(start), .stop(stop), .min_inc(min_inc), .hour_inc(hour_inc),
        .countdown_mode(countdown_mode)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: sampled history, accepted levels, hold ages
    bit m_s1 [5];
    bit m_s2 [5];
    bit m_deb [5];
    bit m_deb_d [5];
    int m_run [5];
    int m_age [2];
    bit e_start, e_stop, e_mode;
    bit e_inc [2];

    // Per-phase observation counters
    int cyc, n_start, n_stop, n_min, n_hour;
    int f_start, f_stop, f_min, f_hour, f_mode_rise, f_mode_fall;
    bit prev_mode;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_deb[i] = 1'b0; m_deb_d[i] = 1'b0; m_run[i] = 0;
        end
        m_age[0] = 0; m_age[1] = 0;
        e_start = 1'b0; e_stop = 1'b0; e_mode = 1'b0; e_inc[0] = 1'b0; e_inc[1] = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using inputs present at that edge
    task automatic model_edge();
        bit raw [5];
        bit r_start, r_stop;
        raw[0] = btn_start_raw; raw[1] = btn_stop_raw; raw[2] = btn_min_raw;
        raw[3] = btn_hour_raw;  raw[4] = sw_mode_raw;
        r_start = m_deb[0] && !m_deb_d[0];
        r_stop  = m_deb[1] && !m_deb_d[1];
        e_stop  = r_stop;
        e_start = r_start && !r_stop;
        e_mode  = m_deb[4];
        for (int k = 0; k < 2; k++) begin
            if (!m_deb[k+2]) begin
                e_inc[k] = 1'b0;
            end else if (!m_deb_d[k+2]) begin
                m_age[k] = 0;
                e_inc[k] = 1'b1;
            end else begin
                m_age[k]++;
                e_inc[k] = (m_age[k] == REP_DELAY) ||
                           (m_age[k] > REP_DELAY && ((m_age[k] - REP_DELAY) % REP_RATE) == 0);
            end
        end
        for (int i = 0; i < 5; i++) begin
            m_deb_d[i] = m_deb[i];
            if (m_s2[i] != m_deb[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == DEB_CNT) begin
                m_deb[i] = m_s2[i];
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
    endtask

    task automatic compare_outputs();
        check_val("start", int'(start), int'(e_start));
        check_val("stop", int'(stop), int'(e_stop));
        check_val("min_inc", int'(min_inc), int'(e_inc[0]));
        check_val("hour_inc", int'(hour_inc), int'(e_inc[1]));
        check_val("countdown_mode", int'(countdown_mode), int'(e_mode));
    endtask

    task automatic phase_begin();
        cyc = 0; n_start = 0; n_stop = 0; n_min = 0; n_hour = 0;
        f_start = -1; f_stop = -1; f_min = -1; f_hour = -1;
        f_mode_rise = -1; f_mode_fall = -1;
        prev_mode = countdown_mode;
    endtask

    // Advance one edge, update model, compare #1 after the edge, collect stats
    task automatic tick();
        @(posedge clk_100Hz);
        if (rst) model_reset();
        else model_edge();
        #1;
        compare_outputs();
        cyc++;
        if (start)    begin n_start++; if (f_start < 0) f_start = cyc; end
        if (stop)     begin n_stop++;  if (f_stop  < 0) f_stop  = cyc; end
        if (min_inc)  begin n_min++;   if (f_min   < 0) f_min   = cyc; end
        if (hour_inc) begin n_hour++;  if (f_hour  < 0) f_hour  = cyc; end
        if (countdown_mode && !prev_mode && f_mode_rise < 0) f_mode_rise = cyc;
        if (!countdown_mode && prev_mode && f_mode_fall < 0) f_mode_fall = cyc;
        prev_mode = countdown_mode;
    endtask

    // Assert reset between edges, check outputs drop at once, release between edges
    task automatic apply_reset(input int edges);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_async_start", int'(start), 0);
        check_val("rst_async_min_inc", int'(min_inc), 0);
        check_val("rst_async_hour_inc", int'(hour_inc), 0);
        check_val("rst_async_mode", int'(countdown_mode), 0);
        compare_outputs();
        repeat (edges) tick();
        #2 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        phase_begin();
        repeat (3) tick();
        check_val("reset_start", int'(start), 0);
        check_val("reset_stop", int'(stop), 0);
        #2 rst = 1'b0;
        repeat (5) tick();

        // Single start press, no pulse on release
        phase_begin();
        btn_start_raw = 1'b1; repeat (10) tick();
        btn_start_raw = 1'b0; repeat (15) tick();
        check_val("start_latency", f_start, 6);
        check_val("start_count", n_start, 1);

        // Short stop glitch is filtered, real press is accepted
        phase_begin();
        btn_stop_raw = 1'b1; repeat (2) tick();
        btn_stop_raw = 1'b0; repeat (10) tick();
        check_val("stop_glitch_count", n_stop, 0);
        phase_begin();
        btn_stop_raw = 1'b1; repeat (4) tick();
        btn_stop_raw = 1'b0; repeat (12) tick();
        check_val("stop_press_count", n_stop, 1);

        // Simultaneous start and stop: stop wins
        phase_begin();
        btn_start_raw = 1'b1; btn_stop_raw = 1'b1; repeat (10) tick();
        btn_start_raw = 1'b0; btn_stop_raw = 1'b0; repeat (10) tick();
        check_val("both_stop_count", n_stop, 1);
        check_val("both_start_count", n_start, 0);

        // Minute hold-to-repeat, then a short hold
        phase_begin();
        btn_min_raw = 1'b1; repeat (120) tick();
        btn_min_raw = 1'b0; repeat (30) tick();
        check_val("min_hold_count", n_min, 5);
        check_val("min_hold_first", f_min, 6);
        phase_begin();
        btn_min_raw = 1'b1; repeat (30) tick();
        btn_min_raw = 1'b0; repeat (30) tick();
        check_val("min_short_count", n_min, 1);

        // Hour held while minute is tapped three times
        phase_begin();
        btn_hour_raw = 1'b1;
        for (int i = 0; i < 200; i++) begin
            btn_min_raw = (i >= 20 && i < 80 && ((i - 20) % 20) < 6);
            tick();
        end
        btn_hour_raw = 1'b0; btn_min_raw = 1'b0; repeat (20) tick();
        check_val("hour_hold_count", n_hour, 9);
        check_val("min_tap_count", n_min, 3);

        // Mode switch level
        phase_begin();
        sw_mode_raw = 1'b1; repeat (40) tick();
        sw_mode_raw = 1'b0; repeat (20) tick();
        check_val("mode_rise_edge", f_mode_rise, 6);
        check_val("mode_fall_edge", f_mode_fall, 46);

        // Reset in the middle of a minute hold
        phase_begin();
        btn_min_raw = 1'b1; repeat (70) tick();
        check_val("pre_rst_min_count", n_min, 2);
        apply_reset(3);
        phase_begin();
        repeat (10) tick();
        check_val("post_rst_min_first", f_min, 6);
        check_val("post_rst_min_count", n_min, 1);
        btn_min_raw = 1'b0; repeat (20) tick();

        // Random activity on all inputs
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 11) == 0) btn_start_raw = ~btn_start_raw;
            if ($urandom_range(0, 11) == 0) btn_stop_raw  = ~btn_stop_raw;
            if ($urandom_range(0, 29) == 0) btn_min_raw   = ~btn_min_raw;
            if ($urandom_range(0, 29) == 0) btn_hour_raw  = ~btn_hour_raw;
            if ($urandom_range(0, 19) == 0) sw_mode_raw   = ~sw_mode_raw;
            if (i == 450) apply_reset(2);
            else tick();
        end
        btn_start_raw = 1'b0; btn_stop_raw = 1'b0; btn_min_raw = 1'b0;
        btn_hour_raw = 1'b0; sw_mode_raw = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stopwatch_btn_ctrl.md
Name: stopwatch_btn_ctrl

Overview:
Input conditioning stage upstream of the stopwatch control logic, in the clk_100Hz domain. Synchronises and debounces four raw push-buttons and one slide switch. Emits single-cycle command pulses (start, stop, min_inc, hour_inc) and a clean countdown_mode level. Adds hold-to-repeat on the two time-set buttons so countdown presets can be dialled quickly.

Parameters:
DEB_CNT, 3, consecutive stable cycles needed to accept a level change (30 ms at 100 Hz); legal range 1..15
REP_DELAY, 50, cycles from the initial pulse to the first auto-repeat pulse (500 ms)
REP_RATE, 20, cycles between subsequent auto-repeat pulses (200 ms)

Ports:
clk_100Hz  in  1  100 Hz system timing clock
rst  in  1  asynchronous, active-high reset
btn_start_raw  in  1  raw start button, active high, asynchronous to clk
btn_stop_raw  in  1  raw stop button, active high
btn_min_raw  in  1  raw minute-increment button, active high
btn_hour_raw  in  1  raw hour-increment button, active high
sw_mode_raw  in  1  raw countdown-mode slide switch, 1 = countdown
start  out  1  one-cycle start command pulse
stop  out  1  one-cycle stop command pulse
min_inc  out  1  one-cycle minute-increment pulse, auto-repeating
hour_inc  out  1  one-cycle hour-increment pulse, auto-repeating
countdown_mode  out  1  debounced mode level

Behaviour:
- Reset: rst asserted, asynchronous, active-high, clock clk_100Hz. All outputs are 0. Synchroniser flops, debounced levels, debounce counters and repeat counters are 0. Repeat FSMs go to IDLE.
- Synchroniser: each raw input passes through 2 flops (s1, s2). No logic sits between s1 and s2.
- Debounce, per input:
  - A 4-bit counter increments on each edge where s2 != deb and clears on any edge where s2 == deb.
  - When the counter reaches DEB_CNT, deb takes the value of s2 and the counter clears.
  - A glitch shorter than DEB_CNT cycles never changes deb.
- Latency: a raw rising edge first sampled at edge 1 sets deb at edge 2+DEB_CNT. The registered output pulse or level is high after edge 3+DEB_CNT. With defaults this is 6 edges.
- start and stop:
  - Each is a registered rising-edge detect of its deb level, so exactly one cycle wide per press.
  - Release produces no pulse.
  - If both would pulse in the same cycle, stop wins and start is suppressed (dropped, not delayed).
- countdown_mode: registered copy of the switch deb level; no pulse behaviour.
- min_inc and hour_inc each use an independent repeat FSM:
  - IDLE: on deb rising, emit a pulse, load rep_cnt = REP_DELAY-1, go to WAIT.
  - WAIT: decrement rep_cnt each cycle. At 0 with deb still high, emit a pulse, load REP_RATE-1, go to REPEAT.
  - REPEAT: same countdown. At 0, emit a pulse and reload REP_RATE-1.
  - WAIT or REPEAT with deb low: return to IDLE that cycle with no pulse; rep_cnt clears.
  - Resulting pulse times: P (initial), P+REP_DELAY, then every REP_RATE cycles after that.
- The two inc buttons run independently; both may pulse in the same cycle.
- This block applies no mode gating. min_inc and hour_inc are emitted in any mode; the downstream logic decides whether to use them.
- rst mid-press or mid-repeat: all state clears immediately and outputs drop. A button still held at reset release counts as a new press and produces a pulse at edge 3+DEB_CNT after release.
- Width rules:
  - rep_cnt is 8 bits; REP_DELAY and REP_RATE must be in 1..255.
  - With REP_RATE = 1, a pulse is emitted every cycle in REPEAT.

Test Plan:
- Reset, then btn_start_raw high for 10 cycles -> start high for exactly 1 cycle, at the 6th edge after the first sampling edge; no pulse on release.
- btn_stop_raw glitch high for 2 cycles (shorter than DEB_CNT=3) -> stop stays 0 throughout; a later 4-cycle press -> one stop pulse.
- btn_start_raw and btn_stop_raw rise on the same edge and are held -> stop pulses once, start stays 0.
- btn_min_raw held 120 cycles -> min_inc pulses at P, P+50, P+70, P+90, P+110 (5 pulses). Release -> no further pulses. Then a 30-cycle hold -> exactly 1 pulse.
- btn_hour_raw held while btn_min_raw is tapped 3 times -> hour_inc repeat cadence is unaffected; exactly 3 extra min_inc pulses.
- sw_mode_raw toggled 1 then back to 0 after 40 cycles -> countdown_mode rises 6 edges after the toggle and falls 6 edges after the return. rst asserted mid-hold of btn_min_raw -> all outputs 0 at once, and one pulse 6 edges after release.
